// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave). Responses return in request order.
interface if_fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited imem requests,
// queues returned words and drives the IF/ID register. Macro IF_FETCH_BYPASS_EN
// lets a kept response go straight into IF/ID when the queue is empty.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    if_fetch_stage_if.master       imem,
    input  logic                   id_stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            if_id_IR,
    output logic [31:0]            if_id_PC,
    output logic [31:0]            if_id_NPC,
    output logic                   if_id_valid_inst
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [31:0]   fq_inst_q [FQ_DEPTH];
    logic [31:0]   fq_pc_q   [FQ_DEPTH];

    logic [31:0]   ir_q, ir_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   npc_q, npc_d;
    logic          vld_q, vld_d;

    logic [CW:0]   credit_used;
    logic          req_valid;
    logic          req_fire;
    logic          keep;
    logic          bypass;
    logic          push;
    logic          pop;

    // Gated by rst so no request is presented while the stage is held in reset.
    assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};
    assign req_valid   = rst & ~redirect_valid & (credit_used < DEPTH_W);
    assign req_fire    = req_valid & imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign keep = imem.imem_resp_valid & ~redirect_valid & (drop_q == '0);
`ifdef IF_FETCH_BYPASS_EN
    assign bypass = keep & (cnt_q == '0) & ~id_stall;
`else
    assign bypass = 1'b0;
`endif
    assign push = keep & ~bypass;
    assign pop  = ~redirect_valid & ~id_stall & (cnt_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + CW'(req_fire) - CW'(imem.imem_resp_valid);
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        vld_d      = vld_q;

        if (redirect_valid) begin
            // Everything still in flight, minus the word landing now, belongs to the old path.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = out_q - CW'(imem.imem_resp_valid);
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            ir_d       = NOP_INST;
            vld_d      = 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem.imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            rd_d  = rd_q + PW'(pop);
            wr_d  = wr_q + PW'(push);

            if (id_stall) begin
                vld_d = vld_q;
            end else if (pop) begin
                ir_d  = fq_inst_q[rd_q];
                pc_d  = fq_pc_q[rd_q];
                npc_d = fq_pc_q[rd_q] + 32'd4;
                vld_d = 1'b1;
            end else if (bypass) begin
                ir_d  = imem.imem_resp_data;
                pc_d  = resp_pc_q;
                npc_d = resp_pc_q + 32'd4;
                vld_d = 1'b1;
            end else begin
                ir_d  = NOP_INST;
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            ir_q       <= NOP_INST;
            pc_q       <= '0;
            npc_q      <= 32'd4;
            vld_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            vld_q      <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_inst_q[wr_q] <= imem.imem_resp_data;
            fq_pc_q[wr_q]   <= resp_pc_q;
        end
    end

    assign if_id_IR         = ir_q;
    assign if_id_PC         = pc_q;
    assign if_id_NPC        = npc_q;
    assign if_id_valid_inst = vld_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (cnt_q == FULL_CNT)));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency in-order memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_id_IR, if_id_PC, if_id_NPC;
    logic        if_id_valid_inst;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2),
        .NOP_INST (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (bus.master),
        .id_stall         (id_stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_id_IR         (if_id_IR),
        .if_id_PC         (if_id_PC),
        .if_id_NPC        (if_id_NPC),
        .if_id_valid_inst (if_id_valid_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: request accepted at edge t returns at edge t+lat, in order.
    int unsigned lat = 1;
    logic [3:0]  pv;
    logic [31:0] pa [4];
    int          mon_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv      <= '0;
            mon_out <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= pv[i+1];
                pa[i] <= pa[i+1];
            end
            pv[3] <= 1'b0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pv[lat-1] <= 1'b1;
                pa[lat-1] <= bus.imem_req_addr;
            end
            mon_out <= mon_out + ((bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0)
                               - (pv[0] ? 1 : 0);
        end
    end

    assign bus.imem_resp_valid = pv[0];
    assign bus.imem_resp_data  = mem_word(pa[0]);

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc = 32'h0;
    int          n_inst = 0;
    bit          got_first = 1'b0;
    logic [31:0] first_pc = '0;
    logic [31:0] prev_ir = NOP, prev_pc = '0;
    logic        prev_vld = 1'b0;

    // One clock; classifies the IF/ID contents produced by that edge and checks them.
    task automatic cyc();
        @(posedge clk);
        #1;
        checks++;
        if (redirect_valid) begin
            if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) begin
                failures++;
                $display("FAIL redirect_flush: valid=%b IR=%h, required valid=0 IR=%h",
                         if_id_valid_inst, if_id_IR, NOP);
            end
            exp_pc = redirect_pc;
        end else if (id_stall) begin
            if (if_id_valid_inst !== prev_vld || if_id_IR !== prev_ir || if_id_PC !== prev_pc) begin
                failures++;
                $display("FAIL stall_hold: valid=%b IR=%h PC=%h, required valid=%b IR=%h PC=%h",
                         if_id_valid_inst, if_id_IR, if_id_PC, prev_vld, prev_ir, prev_pc);
            end
        end else if (if_id_valid_inst === 1'b1) begin
            if (if_id_PC !== exp_pc || if_id_IR !== mem_word(exp_pc) || if_id_NPC !== exp_pc + 32'd4) begin
                failures++;
                $display("FAIL stream: PC=%h IR=%h NPC=%h, required PC=%h IR=%h NPC=%h",
                         if_id_PC, if_id_IR, if_id_NPC, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
            if (!got_first) begin
                got_first = 1'b1;
                first_pc  = if_id_PC;
            end
            exp_pc = exp_pc + 32'd4;
            n_inst++;
        end else begin
            if (if_id_IR !== NOP || if_id_valid_inst !== 1'b0) begin
                failures++;
                $display("FAIL bubble_nop: valid=%b IR=%h, required valid=0 IR=%h",
                         if_id_valid_inst, if_id_IR, NOP);
            end
        end
        prev_ir  = if_id_IR;
        prev_pc  = if_id_PC;
        prev_vld = if_id_valid_inst;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || if_id_PC !== 32'h0 ||
            if_id_NPC !== 32'h4 || bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b IR=%h PC=%h NPC=%h req_valid=%b, required 0 %h 0 4 0",
                     if_id_valid_inst, if_id_IR, if_id_PC, if_id_NPC, bus.imem_req_valid, NOP);
        end
    endtask

    task automatic test_latency();
        int start;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req: valid=%b addr=%h, required 1 00000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        cyc();
        checks++;
        if (bus.imem_req_addr !== 32'h4) begin
            failures++;
            $display("FAIL second_addr: addr=%h, required 00000004", bus.imem_req_addr);
        end
        cyc();
        checks++;
        if (if_id_valid_inst !== BYP) begin
            failures++;
            $display("FAIL latency_c2: valid=%b, required %b", if_id_valid_inst, BYP);
        end
        cyc();
        checks++;
        if (if_id_valid_inst !== 1'b1 || if_id_PC !== (BYP ? 32'h4 : 32'h0)) begin
            failures++;
            $display("FAIL latency_c3: valid=%b PC=%h, required 1 %h",
                     if_id_valid_inst, if_id_PC, BYP ? 32'h4 : 32'h0);
        end
        start = n_inst;
        repeat (10) cyc();
        checks++;
        if (n_inst - start < 4) begin
            failures++;
            $display("FAIL stream_progress: %0d instructions, required at least 4", n_inst - start);
        end
    endtask

    task automatic test_stall();
        int start;
        id_stall = 1'b1;
        repeat (3) cyc();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_credits: req_valid=%b, required 0", bus.imem_req_valid);
        end
        id_stall = 1'b0;
        start = n_inst;
        repeat (8) cyc();
        checks++;
        if (n_inst - start < 3) begin
            failures++;
            $display("FAIL stall_resume: %0d instructions, required at least 3", n_inst - start);
        end
    endtask

    task automatic test_redirect_outstanding();
        int waited = 0;
        lat = 3;
        while (mon_out != 2 && waited < 20) begin
            cyc();
            waited++;
        end
        checks++;
        if (mon_out != 2) begin
            failures++;
            $display("FAIL reach_outstanding: outstanding=%0d, required 2", mon_out);
        end
        got_first = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        repeat (20) cyc();
        checks++;
        if (!got_first || first_pc !== 32'h100) begin
            failures++;
            $display("FAIL redirect_target: seen=%b first_pc=%h, required 1 00000100", got_first, first_pc);
        end
    endtask

    task automatic test_redirect_stall();
        id_stall = 1'b1;
        repeat (2) cyc();
        got_first = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        cyc();
        checks++;
        if (bus.imem_req_addr !== 32'h400) begin
            failures++;
            $display("FAIL redirect_stall_addr: addr=%h, required 00000400", bus.imem_req_addr);
        end
        redirect_valid = 1'b0;
        cyc();
        id_stall = 1'b0;
        repeat (20) cyc();
        checks++;
        if (!got_first || first_pc !== 32'h400) begin
            failures++;
            $display("FAIL redirect_stall_target: seen=%b first_pc=%h, required 1 00000400", got_first, first_pc);
        end
    endtask

    task automatic test_back_to_back_redirect();
        got_first = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        redirect_pc = 32'h300;
        cyc();
        redirect_valid = 1'b0;
        repeat (20) cyc();
        checks++;
        if (!got_first || first_pc !== 32'h300) begin
            failures++;
            $display("FAIL b2b_redirect: seen=%b first_pc=%h, required 1 00000300", got_first, first_pc);
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] a0;
        bus.imem_req_ready = 1'b0;
        a0 = bus.imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (bus.imem_req_addr !== a0) begin
                failures++;
                $display("FAIL addr_stable: cycle %0d addr=%h, required %h", i, bus.imem_req_addr, a0);
            end
        end
        checks++;
        if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP || bus.imem_req_valid !== 1'b1 || mon_out != 0) begin
            failures++;
            $display("FAIL ready_low_drain: valid=%b IR=%h req_valid=%b outstanding=%0d, required 0 %h 1 0",
                     if_id_valid_inst, if_id_IR, bus.imem_req_valid, mon_out, NOP);
        end
        bus.imem_req_ready = 1'b1;
        got_first = 1'b0;
        repeat (12) cyc();
        checks++;
        if (!got_first || first_pc !== a0) begin
            failures++;
            $display("FAIL ready_resume: seen=%b first_pc=%h, required 1 %h", got_first, first_pc, a0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_redirect_outstanding();
        test_redirect_stall();
        test_back_to_back_redirect();
        test_ready_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
